// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-ported 64-word data memory between the CPU memory stage
// and a secondary requester (DMA / debug loader). The CPU normally has
// priority. When the fairness option is built in, a starvation counter forces
// the DMA in for one cycle after it has been refused MAX_WAIT cycles in a row.
// Read data from the memory (registered, one cycle of latency) is steered back
// to whichever port issued the read.
//
// Build option:
//   DMEM_ARB_FAIRNESS_EN  defined   -> starvation counter + DMA_FORCE slot
//                         undefined -> strict CPU priority (DMA may starve)
//
// Ports:
//   CLOCK_50, RESET_N       clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata   CPU access request
//   cpu_stall               CPU must hold its request (DMA owns the memory)
//   cpu_rvalid/cpu_rdata    load data for the CPU's previous granted read
//   dma_req/we/addr/wdata   DMA access request (held stable until granted)
//   dma_gnt                 DMA access accepted this cycle
//   dma_rvalid/dma_rdata    read data for the DMA's previous granted read
//   mem_we/addr/wdata       memory command from the winning port
//   mem_rdata               memory read data, valid the cycle after the address
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        CPU_PRI   = 1'b0,
        DMA_FORCE = 1'b1
    } owner_e;

    owner_e owner_s;
    logic   cpu_sel_s;
    logic   dma_sel_s;
    logic   cpu_win_s;
    logic   dma_win_s;
    logic   rsel_cpu_r;
    logic   rsel_dma_r;

    // The 4-bit starvation counter cannot represent a threshold outside 1..15.
    if ((MAX_WAIT < 32'sd1) || (MAX_WAIT > 32'sd15)) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be in 1..15");
    end

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    owner_e     owner_r;
    owner_e     owner_nxt_s;
    logic [3:0] wait_cnt_r;
    logic [3:0] wait_cnt_nxt_s;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'd15) begin
            r = 4'd15;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

    // Owner state and starvation counter registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            owner_r    <= CPU_PRI;
            wait_cnt_r <= 4'd0;
        end else begin
            owner_r    <= owner_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Count consecutive refusals; the forced slot lasts exactly one cycle.
    always_comb begin
        wait_cnt_nxt_s = 4'd0;
        owner_nxt_s    = CPU_PRI;
        if (dma_req && !dma_sel_s) begin
            wait_cnt_nxt_s = sat_inc4(wait_cnt_r);
        end else begin
            wait_cnt_nxt_s = 4'd0;
        end
        case (owner_r)
            CPU_PRI: begin
                if (wait_cnt_nxt_s >= MAX_WAIT_C) begin
                    owner_nxt_s = DMA_FORCE;
                end else begin
                    owner_nxt_s = CPU_PRI;
                end
            end
            DMA_FORCE: owner_nxt_s = CPU_PRI;
            default:   owner_nxt_s = CPU_PRI;
        endcase
    end

    assign owner_s = owner_r;
`else
    assign owner_s = CPU_PRI;
`endif

    // Priority decision for this cycle from the current owner and requests.
    always_comb begin
        cpu_sel_s = 1'b0;
        dma_sel_s = 1'b0;
        case (owner_s)
            CPU_PRI: begin
                if (cpu_req) begin
                    cpu_sel_s = 1'b1;
                end else if (dma_req) begin
                    dma_sel_s = 1'b1;
                end else begin
                    cpu_sel_s = 1'b0;
                    dma_sel_s = 1'b0;
                end
            end
            DMA_FORCE: begin
                if (dma_req) begin
                    dma_sel_s = 1'b1;
                end else if (cpu_req) begin
                    cpu_sel_s = 1'b1;
                end else begin
                    cpu_sel_s = 1'b0;
                    dma_sel_s = 1'b0;
                end
            end
            default: begin
                cpu_sel_s = 1'b0;
                dma_sel_s = 1'b0;
            end
        endcase
    end

    // Nothing is granted while reset is asserted, so every output reads 0.
    assign cpu_win_s = cpu_sel_s & RESET_N;
    assign dma_win_s = dma_sel_s & RESET_N;

    assign cpu_stall = cpu_req & dma_win_s;
    assign dma_gnt   = dma_win_s;

    // Memory command mux: the winner drives the memory, otherwise idle zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (cpu_win_s) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_win_s) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
        end
    end

    // Remember which port issued a read so the registered data goes back to it.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rsel_cpu_r <= 1'b0;
            rsel_dma_r <= 1'b0;
        end else begin
            rsel_cpu_r <= cpu_sel_s & ~cpu_we;
            rsel_dma_r <= dma_sel_s & ~dma_we;
        end
    end

    assign cpu_rvalid = rsel_cpu_r;
    assign dma_rvalid = rsel_dma_r;
    assign cpu_rdata  = rsel_cpu_r ? mem_rdata : {DATA_W{1'b0}};
    assign dma_rdata  = rsel_dma_r ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported 64-word data memory between the pipelined CPU's memory stage and a secondary requester (DMA/debug loader). The CPU has priority. A starvation counter guarantees the secondary port a slot. The arbiter stalls the CPU while the secondary port owns the memory, and routes the registered read data back to whichever port issued the access.

## Interface
Parameters:
- ADDR_W, 6, word address width (64 words)
- DATA_W, 32, data width
- MAX_WAIT, 4, maximum consecutive cycles the DMA may be refused before it is forced in (1..15)

Ports:
- CLOCK_50  in  1  system clock, rising edge
- RESET_N  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU memory access this cycle (load or store)
- cpu_we  in  1  CPU store
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_stall  out  1  CPU must hold its request and freeze the pipeline
- cpu_rvalid  out  1  cpu_rdata holds load data for the CPU's previous granted read
- cpu_rdata  out  DATA_W  load data
- dma_req  in  1  DMA access request, held with stable fields until granted
- dma_we  in  1  DMA write
- dma_addr  in  ADDR_W  DMA word address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  dma_rdata valid
- dma_rdata  out  DATA_W  read data
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the address

## Operation
- State register `owner` has two states, CPU_PRI and DMA_FORCE. It resets to CPU_PRI. A 4-bit `wait_cnt` resets to 0.
- Grant (combinational from the current state and requests):
  - CPU_PRI: the CPU wins if cpu_req=1; otherwise the DMA wins if dma_req=1.
  - DMA_FORCE: the DMA wins if dma_req=1; otherwise the CPU wins.
- cpu_stall = cpu_req & DMA granted. dma_gnt = DMA granted.
- Memory mux: the winner drives mem_addr, mem_wdata and mem_we. With no winner: mem_we=0, mem_addr=0, mem_wdata=0.
- wait_cnt:
  - Increments (saturating at 15) each cycle dma_req=1 and the DMA is not granted.
  - Clears when the DMA is granted or dma_req=0.
- Transitions:
  - CPU_PRI -> DMA_FORCE when the next value of wait_cnt ≥ MAX_WAIT.
  - DMA_FORCE -> CPU_PRI after exactly one cycle, whether or not the DMA was granted.
- Read return:
  - Flops rsel_cpu and rsel_dma are set on the edge after a granted read (we=0) by that port; otherwise they clear.
  - cpu_rvalid=rsel_cpu and dma_rvalid=rsel_dma.
  - Each rdata = mem_rdata when its rvalid=1, else 0.
- Writes produce no rvalid.

## Timing
- Grant, stall and memory outputs are combinational, with zero-cycle latency from the request.
- Read latency is 1 cycle: address in cycle T, rvalid and data in cycle T+1.
- Back-to-back grants to alternating ports are allowed every cycle.
- Reset values:
  - Every output is 0 (mem_we, mem_addr, mem_wdata, stall, gnt, both rvalid, both rdata).
  - owner=CPU_PRI, wait_cnt=0.
- Reset asserted mid-operation: the in-flight read is dropped (rvalid cleared, no data returned), and a forced slot is cancelled.
- Both ports requesting in the same cycle: resolved strictly by `owner`; only one port is granted, and the loser holds.
- A stalled CPU whose request disappears (pipeline flush) simply gets no grant; no state is retained for it.
- A DMA dropping dma_req before its grant is legal; wait_cnt clears.

## Configuration
- `DMEM_ARB_FAIRNESS_EN` defined: starvation counter and DMA_FORCE behave as described.
- Not defined: wait_cnt and DMA_FORCE are not built, and owner stays CPU_PRI (strict CPU priority). The DMA can starve indefinitely under continuous cpu_req.

## Test plan
- Reset with both requests high (RESET_N=0) -> all outputs 0, no grant. After release with cpu_req=1 and dma_req=0: mem_we follows cpu_we, cpu_stall=0.
- CPU store addr 5 data 0xDEADBEEF, next cycle CPU load addr 5 -> mem_we=1 then 0. The cycle after the load: cpu_rvalid=1, cpu_rdata=0xDEADBEEF, dma_rvalid=0.
- cpu_req continuously high and dma_req high from cycle 0, MAX_WAIT=4 -> DMA refused cycles 0–3, dma_gnt=1 and cpu_stall=1 in cycle 4, CPU granted again in cycle 5. Pattern repeats every 5 cycles. Without the macro, dma_gnt never rises.
- DMA alone reads addr 63 holding 0x12345678 -> dma_gnt=1 the same cycle, then dma_rvalid=1 and dma_rdata=0x12345678 next cycle; cpu_rvalid stays 0.
- Forced DMA read in cycle 4, RESET_N pulsed low in cycle 5 -> dma_rvalid=0 in cycle 5. After release, owner=CPU_PRI and wait_cnt=0 (next contention waits a full MAX_WAIT).
- Forced slot with dma_req dropped just before it -> CPU granted in that cycle, cpu_stall=0, state returns to CPU_PRI.
